// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stage occupancy encodings, the RV32 NOP
// instruction and the field layout of the IF/ID payload.
package cpu_pipe_pkg;

  // Occupancy encodings. The numeric value equals the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // addi x0, x0, 0 -- the canonical RV32 bubble.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // IF/ID payload layout: {pc_next, instruction}.
  localparam int IFID_WIDTH     = 64;
  localparam int IFID_INSTR_LSB = 0;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_PC_LSB    = 32;
  localparam int IFID_PC_MSB    = 63;

  // Bubble value used for IF/ID after reset or squash.
  localparam logic [63:0] IFID_RESET_VALUE = {32'd0, RV32_NOP};

  // Assemble an IF/ID payload from its two fields.
  function automatic logic [63:0] ifid_pack(input logic [31:0] pc_next,
                                            input logic [31:0] instr);
    return {pc_next, instr};
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry skid buffer.
// The main entry drives out_*; the skid entry catches the one word that
// upstream may push in the cycle after downstream stalls. in_ready, out_valid
// and count are all registered, so no combinational path exists from
// out_ready or in_valid to any output.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next occupancy and entry contents from the current handshakes.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_data_r;
    skid_nxt_s  = skid_data_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          main_nxt_s  = in_data;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && out_fire_s) begin
          main_nxt_s  = in_data;
          state_nxt_s = ST_ONE;
        end else if (in_fire_s) begin
          skid_nxt_s  = in_data;
          state_nxt_s = ST_FULL;
        end else if (out_fire_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path can move data.
        if (out_fire_s) begin
          main_nxt_s  = skid_data_r;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Occupancy and both entries; reset and flush both squash to the bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_r     <= ST_EMPTY;
      main_data_r <= RESET_VALUE;
      skid_data_r <= RESET_VALUE;
    end else begin
      state_r     <= state_nxt_s;
      main_data_r <= main_nxt_s;
      skid_data_r <= skid_nxt_s;
    end
  end

  // Handshake outputs decoded one cycle early so they leave from flops.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_FULL);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign count     = state_r;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register for the RV32IM pipeline. It is the successor to the fixed 32-bit IF/ID register and generalises it in payload width and reset/bubble value. It adds valid/ready flow control, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/jump squash. It is instantiated between any two pipeline stages, first IF/ID with payload {pc_next, instruction}.

## Interface
- WIDTH, 64, payload width in bits (IF/ID: 32-bit pc_next in [63:32], instruction in [31:0])
- RESET_VALUE, {WIDTH{1'b0}}, value driven on out_data after reset or flush (IF/ID: pc_next 0, instruction = NOP 32'h00000013)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; highest priority
- flush  input  1  synchronous squash of all held entries; priority below reset
- in_valid  input  1  upstream has payload
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  main entry holds valid payload
- out_ready  input  1  downstream accepts (low = stall)
- out_data  output  WIDTH  main entry payload
- count  output  2  occupancy 0..2

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_*) and skid entry, each with a valid bit; occupancy states EMPTY(0), ONE(1), FULL(2).
- EMPTY: in_fire -> main <= in_data, go ONE.
- ONE: in_fire & out_fire -> main <= in_data, stay ONE; in_fire only -> skid <= in_data, go FULL; out_fire only -> go EMPTY; neither -> hold.
- FULL: in_ready = 0; out_fire -> main <= skid, go ONE; else hold.
- Ordering strictly FIFO; no payload is ever duplicated or dropped except by flush/reset.
- flush: both entries invalidated, out_data <= RESET_VALUE, count <= 0, go EMPTY. Any in_fire in the same cycle is consumed upstream and discarded.
- reset: same effect as flush. reset and flush together behave as reset.
- out_data changes only when the main entry is loaded, or on reset/flush. When the stage is empty it holds the last value, which downstream must qualify with out_valid.
- Outputs after reset: out_valid 0, in_ready 1, count 0, out_data RESET_VALUE.

## Timing
- Latency: in_fire at edge N -> out_valid with that payload after edge N, i.e. visible in cycle N+1.
- Throughput: one transfer per cycle while out_ready is held high.
- in_ready, out_valid and count are register outputs. There is no combinational path from out_ready or in_valid to any output.
- After out_ready drops, at most one further in_fire is absorbed (into the skid entry) before in_ready falls at the next edge.
- Flush takes effect at the edge it is sampled. In the following cycle out_valid = 0 and in_ready = 1.
- Reset asserted mid-stream: all state is cleared at that edge, regardless of in_valid, out_ready or flush.

## Structure
- Shared header/package cpu_pipe_pkg: occupancy encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; RV32 NOP constant 32'h00000013; IF/ID payload field offsets.
- No sub-module. Both entries and the control FSM are inlined in one always block plus registered outputs.
- IF/ID wiring: WIDTH=64, RESET_VALUE={32'd0, NOP}. The flush input is driven by branch-taken from EX, and the out_ready input by the hazard unit's stall.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_data=64'hAAAA -> out_valid 0, in_ready 1, count 0, out_data=RESET_VALUE.
- Streaming: out_ready=1, send 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle after acceptance, count stays 1.
- Back-pressure: stream 0x10,0x11,0x12 with out_ready dropped after the first is accepted -> count reaches 2, in_ready 0, 0x12 held upstream. Release out_ready -> 0x10,0x11,0x12 emerge in order, none lost or duplicated.
- Flush in FULL with in_valid=1 carrying 0x20 -> next cycle out_valid 0, count 0, out_data=RESET_VALUE, 0x20 never appears on the output.
- reset and flush asserted together while in ONE -> identical to reset.
- Randomised in_valid/out_ready, 10k cycles, against a scoreboard FIFO -> order and count match, in_ready never high while count=2.
